hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush and a RUN/WAIT
// FSM that freezes the front of the pipe while a multi-cycle mul/div runs.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rf_re0_id,
    input  logic        rf_re1_id,
    input  logic [4:0]  rf_ra0_id,
    input  logic [4:0]  rf_ra1_id,
    input  logic        rf_we_ex,
    input  logic [4:0]  rf_wa_ex,
    input  logic        mem_rd_ex,
    input  logic        br_taken_ex,
    input  logic        mdu_op_ex,
    input  logic        mdu_done,
    output logic        mdu_go,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic [15:0] stall_cnt,
    output logic        mdu_busy
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t state;
    logic   load_use;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = mem_rd_ex & rf_we_ex & (rf_wa_ex != 5'd0) &
                      ((rf_re0_id & (rf_ra0_id == rf_wa_ex)) |
                       (rf_re1_id & (rf_ra1_id == rf_wa_ex)));

    assign mdu_busy = (state == S_WAIT);

    always_comb begin
        mdu_go       = 1'b0;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (rst) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (state == S_WAIT) begin
            // On mdu_done everything releases so the result moves into MEM
            if (!mdu_done) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end
        end else if (mdu_op_ex) begin
            mdu_go       = 1'b1;
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (br_taken_ex) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            stall_cnt <= 16'd0;
        end else begin
            case (state)
                S_RUN:   if (mdu_op_ex) state <= S_WAIT;
                S_WAIT:  if (mdu_done)  state <= S_RUN;
                default: state <= S_RUN;
            endcase
            if (stall_pc && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expected values worked out by hand.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_re0_id, rf_re1_id;
    logic [4:0]  rf_ra0_id, rf_ra1_id;
    logic        rf_we_ex;
    logic [4:0]  rf_wa_ex;
    logic        mem_rd_ex, br_taken_ex, mdu_op_ex, mdu_done;
    logic        mdu_go, stall_pc, stall_if_id, stall_id_ex;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, mdu_busy;
    logic [15:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
        .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
        .rf_we_ex(rf_we_ex), .rf_wa_ex(rf_wa_ex),
        .mem_rd_ex(mem_rd_ex), .br_taken_ex(br_taken_ex),
        .mdu_op_ex(mdu_op_ex), .mdu_done(mdu_done),
        .mdu_go(mdu_go), .stall_pc(stall_pc),
        .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .stall_cnt(stall_cnt),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    // {go, stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem, busy}
    logic [7:0] outs;
    assign outs = {mdu_go, stall_pc, stall_if_id, stall_id_ex,
                   flush_if_id, flush_id_ex, flush_ex_mem, mdu_busy};

    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_RST   = 8'b0000_1110;
    localparam logic [7:0] O_LU    = 8'b0110_0100;
    localparam logic [7:0] O_BR    = 8'b0000_1100;
    localparam logic [7:0] O_GO    = 8'b1111_0010;
    localparam logic [7:0] O_WAIT  = 8'b0111_0011;
    localparam logic [7:0] O_DONE  = 8'b0000_0001;
    localparam logic [7:0] O_RSTW  = 8'b0000_1111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are then driven well away from the edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        rf_re0_id = 0; rf_re1_id = 0; rf_ra0_id = 0; rf_ra1_id = 0;
        rf_we_ex = 0; rf_wa_ex = 0; mem_rd_ex = 0;
        br_taken_ex = 0; mdu_op_ex = 0; mdu_done = 0;
    endtask

    task automatic set_load(input logic [4:0] wa);
        mem_rd_ex = 1; rf_we_ex = 1; rf_wa_ex = wa;
    endtask

    initial begin
        clr();
        rst = 1;
        cyc();
        #2 chk("reset_outs", 32'(outs), 32'(O_RST));
        chk("reset_cnt", 32'(stall_cnt), 0);
        cyc();
        rst = 0;
        #2 chk("idle", 32'(outs), 32'(O_IDLE));

        // load r5, ID reads r5 on port 1
        cyc(); set_load(5); rf_re1_id = 1; rf_ra1_id = 5;
        #2 chk("load_use_p1", 32'(outs), 32'(O_LU));
        cyc(); clr();
        #2 chk("load_use_1cyc", 32'(outs), 32'(O_IDLE));
        chk("cnt_after_lu", 32'(stall_cnt), 1);

        // load to r0 read as r0 never stalls
        cyc(); set_load(0); rf_re0_id = 1; rf_ra0_id = 0;
        #2 chk("load_r0", 32'(outs), 32'(O_IDLE));
        cyc(); clr(); set_load(7); rf_re0_id = 0; rf_ra0_id = 7;
        #2 chk("cnt_after_r0", 32'(stall_cnt), 1);
        chk("port0_not_read", 32'(outs), 32'(O_IDLE));
        cyc(); clr(); rf_we_ex = 1; rf_wa_ex = 9; rf_re0_id = 1; rf_ra0_id = 9;
        #2 chk("not_a_load", 32'(outs), 32'(O_IDLE));
        cyc(); clr(); set_load(9); rf_re0_id = 1; rf_ra0_id = 9;
        #2 chk("load_use_p0", 32'(outs), 32'(O_LU));

        // branch wins over load-use
        cyc(); clr(); set_load(3); rf_re1_id = 1; rf_ra1_id = 3; br_taken_ex = 1;
        #2 chk("branch_over_lu", 32'(outs), 32'(O_BR));
        cyc(); clr();
        #2 chk("cnt_after_br", 32'(stall_cnt), 2);

        // mdu op, done four cycles later; branch/load-use ignored while waiting
        cyc(); mdu_op_ex = 1; br_taken_ex = 1;
        #2 chk("mdu_go", 32'(outs), 32'(O_GO));
        for (int i = 1; i <= 3; i++) begin
            cyc(); set_load(4); rf_re0_id = 1; rf_ra0_id = 4;
            #2 chk("mdu_wait", 32'(outs), 32'(O_WAIT));
        end
        cyc(); mdu_done = 1;
        #2 chk("mdu_done", 32'(outs), 32'(O_DONE));
        cyc(); clr(); mdu_done = 1;
        #2 chk("done_in_run", 32'(outs), 32'(O_IDLE));
        chk("cnt_after_mdu", 32'(stall_cnt), 6);

        // reset on the second WAIT cycle abandons the op
        cyc(); clr(); mdu_op_ex = 1;
        #2 chk("mdu_go2", 32'(outs), 32'(O_GO));
        cyc();
        #2 chk("mdu_wait2", 32'(outs), 32'(O_WAIT));
        cyc(); rst = 1;
        #2 chk("rst_in_wait", 32'(outs), 32'(O_RSTW));
        cyc(); rst = 0; clr(); mdu_done = 1;
        #2 chk("late_done", 32'(outs), 32'(O_IDLE));
        chk("cnt_after_rst", 32'(stall_cnt), 0);
        cyc(); clr();
        #2 chk("run_after_rst", 32'(outs), 32'(O_IDLE));

        // 70000 consecutive stall cycles saturate the counter
        mdu_op_ex = 1;
        for (int i = 0; i < 70000; i++) cyc();
        #2 chk("cnt_saturate", 32'(stall_cnt), 32'hFFFF);
        chk("still_wait", 32'(outs), 32'(O_WAIT));
        mdu_done = 1;
        cyc(); clr();
        #2 chk("cnt_hold", 32'(stall_cnt), 32'hFFFF);
        chk("final_idle", 32'(outs), 32'(O_IDLE));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
